// File: rtl/phys_reg_free_list.sv
// Rename-stage free list: circular queue of free physical register indices with a
// committed head for one-cycle flush recovery. Define FREE_LIST_DOUBLE_FREE_CHECK_EN for double-free detection.
module phys_reg_free_list #(
  parameter int PHYS_REGS   = 64,
  parameter int ARCH_REGS   = 32,
  parameter int ALLOC_WIDTH = 4,
  parameter int FREE_WIDTH  = 4,
  parameter int PW          = $clog2(PHYS_REGS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ALLOC_WIDTH-1:0]      alloc_valid,
  output logic                        alloc_ready,
  output logic [ALLOC_WIDTH*PW-1:0]   alloc_reg,
  input  logic [FREE_WIDTH-1:0]       commit_valid,
  input  logic [FREE_WIDTH-1:0]       commit_alloc,
  input  logic [FREE_WIDTH*PW-1:0]    commit_free_reg,
  input  logic                        flush,
  output logic [PW:0]                 free_count,
  output logic                        double_free_err
);
  localparam int CW = PW + 1;

  logic [PW-1:0] mem_reg [PHYS_REGS];
  logic [CW-1:0] head_reg, tail_reg, commit_head_reg;
  logic [CW-1:0] head_next, tail_next, commit_head_next;
  logic [CW-1:0] alloc_ofs [ALLOC_WIDTH+1];
  logic [CW-1:0] free_ofs [FREE_WIDTH+1];
  logic [CW-1:0] commit_cnt, alloc_cnt;
  logic [ALLOC_WIDTH-1:0] alloc_fire;
  logic [FREE_WIDTH-1:0]  free_en;
  logic [PW-1:0] free_reg [FREE_WIDTH];
  logic [PW-1:0] wr_idx [FREE_WIDTH];

  assign free_count  = tail_reg - head_reg;
  assign alloc_ready = (free_count >= CW'(ALLOC_WIDTH)) && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < FREE_WIDTH; gi++) begin : g_free_lane
      assign free_reg[gi] = commit_free_reg[gi*PW +: PW];
      // x0 is never returned to the list
      assign free_en[gi]  = commit_valid[gi] && commit_alloc[gi] && (free_reg[gi] != '0);
      assign wr_idx[gi]   = tail_reg[PW-1:0] + free_ofs[gi][PW-1:0];
    end
    for (gi = 0; gi < ALLOC_WIDTH; gi++) begin : g_alloc_lane
      logic [PW-1:0] rd_idx;
      // requests are compacted: lane reads head plus the number of earlier requesting lanes
      assign rd_idx = head_reg[PW-1:0] + alloc_ofs[gi][PW-1:0];
      assign alloc_fire[gi] = alloc_valid[gi] && alloc_ready;
      assign alloc_reg[gi*PW +: PW] = alloc_fire[gi] ? mem_reg[rd_idx] : '0;
    end
  endgenerate

  always_comb begin
    alloc_ofs[0] = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++)
      alloc_ofs[i+1] = alloc_ofs[i] + CW'(alloc_valid[i]);
    free_ofs[0] = '0;
    commit_cnt  = '0;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      free_ofs[j+1] = free_ofs[j] + CW'(free_en[j]);
      // a commit consumes a list entry even when its stale register is x0
      commit_cnt    = commit_cnt + CW'(commit_valid[j] && commit_alloc[j]);
    end
    alloc_cnt        = alloc_ready ? alloc_ofs[ALLOC_WIDTH] : '0;
    tail_next        = tail_reg + free_ofs[FREE_WIDTH];
    commit_head_next = commit_head_reg + commit_cnt;
    head_next        = flush ? commit_head_next : head_reg + alloc_cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg        <= '0;
      commit_head_reg <= '0;
      tail_reg        <= CW'(PHYS_REGS - ARCH_REGS);
      for (int i = 0; i < PHYS_REGS; i++)
        mem_reg[i] <= (i < PHYS_REGS - ARCH_REGS) ? PW'(ARCH_REGS + i) : '0;
    end else begin
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      commit_head_reg <= commit_head_next;
      for (int j = 0; j < FREE_WIDTH; j++)
        if (free_en[j]) mem_reg[wr_idx[j]] <= free_reg[j];
    end
  end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [PHYS_REGS-1:0] in_list_reg, in_list_next;
  logic [CW-1:0] live_cnt, live_ofs;
  logic dup_hit, err_reg;

  always_comb begin
    dup_hit      = 1'b0;
    live_cnt     = tail_reg - commit_head_next;
    live_ofs     = '0;
    in_list_next = in_list_reg;
    for (int j = 0; j < FREE_WIDTH; j++) begin
      if (free_en[j]) begin
        if (in_list_reg[free_reg[j]]) dup_hit = 1'b1;
        for (int k = 0; k < j; k++)
          if (free_en[k] && free_reg[k] == free_reg[j]) dup_hit = 1'b1;
      end
    end
    if (flush) begin
      // rebuild from the entries that survive recovery: commit_head up to the old tail
      in_list_next = '0;
      for (int k = 0; k < PHYS_REGS; k++) begin
        live_ofs = {1'b0, PW'(k) - commit_head_next[PW-1:0]};
        if (live_ofs < live_cnt) in_list_next[mem_reg[k]] = 1'b1;
      end
    end else begin
      for (int i = 0; i < ALLOC_WIDTH; i++)
        if (alloc_fire[i]) in_list_next[alloc_reg[i*PW +: PW]] = 1'b0;
    end
    for (int j = 0; j < FREE_WIDTH; j++)
      if (free_en[j]) in_list_next[free_reg[j]] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_list_reg <= {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
      err_reg     <= 1'b0;
    end else begin
      in_list_reg <= in_list_next;
      err_reg     <= err_reg | dup_hit;
    end
  end

  assign double_free_err = err_reg;
`else
  assign double_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue-based list model predicts each cycle's outputs.
`timescale 1ns/1ps
module tb_phys_reg_free_list;
  localparam int PR = 64, AR = 32, AW = 4, FW = 4, PW = 6, CW = 7;
`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  localparam bit DFC_EN = 1'b1;
`else
  localparam bit DFC_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic [AW-1:0] alloc_valid;
  logic alloc_ready;
  logic [AW*PW-1:0] alloc_reg;
  logic [FW-1:0] commit_valid, commit_alloc;
  logic [FW*PW-1:0] commit_free_reg;
  logic flush;
  logic [PW:0] free_count;
  logic double_free_err;

  always #5 clock = ~clock;

  phys_reg_free_list dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_reg(alloc_reg),
    .commit_valid(commit_valid), .commit_alloc(commit_alloc), .commit_free_reg(commit_free_reg),
    .flush(flush), .free_count(free_count), .double_free_err(double_free_err)
  );

  typedef struct packed {
    logic rdy;
    logic [CW-1:0] fc;
    logic [AW*PW-1:0] regs;
    logic err;
  } exp_t;

  exp_t sb_q[$];
  int lst[$];    // entries from commit_head to tail
  int pool[$];   // registers legally returnable as stale mappings
  int n_spec;    // head - commit_head
  bit m_err;
  int checks = 0, errors = 0;
  logic [AW-1:0] s_av;
  logic [FW-1:0] s_cv, s_ca;
  logic [FW*PW-1:0] s_cfr;
  logic s_fl, s_rdy;

  task automatic idle_inputs();
    alloc_valid = '0; commit_valid = '0; commit_alloc = '0; commit_free_reg = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    lst.delete(); pool.delete(); sb_q.delete();
    for (int r = AR; r < PR; r++) lst.push_back(r);
    for (int r = 1; r < AR; r++) pool.push_back(r);
    n_spec = 0; m_err = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // drive one cycle of stimulus, push its prediction, stop at the falling edge
  task automatic drive_cycle(input logic [AW-1:0] av, input logic [FW-1:0] cv, input logic [FW-1:0] ca,
                             input logic [FW*PW-1:0] cfr, input logic fl, input string tag);
    exp_t e;
    int ofs, fc;
    alloc_valid = av; commit_valid = cv; commit_alloc = ca; commit_free_reg = cfr; flush = fl;
    s_av = av; s_cv = cv; s_ca = ca; s_cfr = cfr; s_fl = fl;
    fc = lst.size() - n_spec;
    e.fc = CW'(fc);
    e.rdy = (fc >= AW) && !fl;
    e.regs = '0;
    ofs = 0;
    for (int i = 0; i < AW; i++) begin
      if (av[i]) begin
        if (e.rdy) e.regs[i*PW +: PW] = PW'(lst[n_spec + ofs]);
        ofs++;
      end
    end
    e.err = m_err;
    s_rdy = e.rdy;
    sb_q.push_back(e);
    @(negedge clock);
    $display("%s av=%b cv=%b ca=%b fl=%b ready=%b fc=%0d regs=%h err=%b",
             tag, av, cv, ca, fl, alloc_ready, free_count, alloc_reg, double_free_err);
  endtask

  // clock edge, then bring the model to the post-edge state
  task automatic advance();
    int k, r;
    bit dup;
    @(posedge clock);
    #1;
    dup = 1'b0;
    for (int j = 0; j < FW; j++) begin
      r = int'(s_cfr[j*PW +: PW]);
      if (s_cv[j] && s_ca[j] && r != 0) begin
        for (int p = n_spec; p < lst.size(); p++) if (lst[p] == r) dup = 1'b1;
        for (int q = 0; q < j; q++)
          if (s_cv[q] && s_ca[q] && int'(s_cfr[q*PW +: PW]) == r) dup = 1'b1;
      end
    end
    m_err = m_err | (dup & DFC_EN);
    if (s_rdy) n_spec += $countones(s_av);
    k = $countones(s_cv & s_ca);
    repeat (k) lst.delete(0);
    n_spec -= k;
    for (int j = 0; j < FW; j++) begin
      r = int'(s_cfr[j*PW +: PW]);
      if (s_cv[j] && s_ca[j] && r != 0) lst.push_back(r);
    end
    if (s_fl) n_spec = 0;
    idle_inputs();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    checks += 2;
    if (free_count !== 7'd32) begin errors++; $display("FAIL in_reset free_count got %0d exp 32", free_count); end
    if (alloc_ready !== 1'b1) begin errors++; $display("FAIL in_reset alloc_ready got %b exp 1", alloc_ready); end
    do_reset();
    drive_cycle('0, '0, '0, '0, 1'b0, "reset_idle");
    e = sb_q.pop_front();
    checks += 5;
    if (alloc_ready !== e.rdy) begin errors++; $display("FAIL reset_idle ready got %b exp %b", alloc_ready, e.rdy); end
    if (free_count !== e.fc) begin errors++; $display("FAIL reset_idle fc got %0d exp %0d", free_count, e.fc); end
    if (alloc_reg !== e.regs) begin errors++; $display("FAIL reset_idle regs got %h exp %h", alloc_reg, e.regs); end
    if (double_free_err !== e.err) begin errors++; $display("FAIL reset_idle err got %b exp %b", double_free_err, e.err); end
    if (alloc_reg !== 24'h0) begin errors++; $display("FAIL reset_idle regs_zero got %h exp 0", alloc_reg); end
    advance();
  endtask

  task automatic test_alloc_all();
    exp_t e;
    do_reset();
    drive_cycle(4'b1111, '0, '0, '0, 1'b0, "alloc_all");
    e = sb_q.pop_front();
    checks += 5;
    if (alloc_ready !== e.rdy) begin errors++; $display("FAIL alloc_all ready got %b exp %b", alloc_ready, e.rdy); end
    if (free_count !== e.fc) begin errors++; $display("FAIL alloc_all fc got %0d exp %0d", free_count, e.fc); end
    if (alloc_reg !== e.regs) begin errors++; $display("FAIL alloc_all regs got %h exp %h", alloc_reg, e.regs); end
    if (double_free_err !== e.err) begin errors++; $display("FAIL alloc_all err got %b exp %b", double_free_err, e.err); end
    if (alloc_reg !== {6'd35, 6'd34, 6'd33, 6'd32}) begin errors++; $display("FAIL alloc_all lanes got %h exp 32..35", alloc_reg); end
    advance();
    checks++;
    if (free_count !== 7'd28) begin errors++; $display("FAIL alloc_all fc_after got %0d exp 28", free_count); end
  endtask

  task automatic test_sparse();
    exp_t e;
    do_reset();
    drive_cycle(4'b1010, '0, '0, '0, 1'b0, "sparse");
    e = sb_q.pop_front();
    checks += 4;
    if (alloc_ready !== e.rdy) begin errors++; $display("FAIL sparse ready got %b exp %b", alloc_ready, e.rdy); end
    if (alloc_reg !== e.regs) begin errors++; $display("FAIL sparse regs got %h exp %h", alloc_reg, e.regs); end
    if (double_free_err !== e.err) begin errors++; $display("FAIL sparse err got %b exp %b", double_free_err, e.err); end
    if (alloc_reg !== {6'd33, 6'd0, 6'd32, 6'd0}) begin errors++; $display("FAIL sparse lanes got %h exp 33/0/32/0", alloc_reg); end
    advance();
    checks++;
    if (free_count !== 7'd30) begin errors++; $display("FAIL sparse fc_after got %0d exp 30", free_count); end
  endtask

  task automatic test_fill_wrap();
    exp_t e;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c < 9)
        drive_cycle(4'b1111, '0, '0, '0, 1'b0, "fill");
      else if (c == 9)
        drive_cycle(4'b1111, 4'b1111, 4'b1111, {6'd35, 6'd34, 6'd33, 6'd32}, 1'b0, "fill_free");
      else
        drive_cycle(4'b1111, '0, '0, '0, 1'b0, "fill_reissue");
      e = sb_q.pop_front();
      checks += 4;
      if (alloc_ready !== e.rdy) begin errors++; $display("FAIL fill_%0d ready got %b exp %b", c, alloc_ready, e.rdy); end
      if (free_count !== e.fc) begin errors++; $display("FAIL fill_%0d fc got %0d exp %0d", c, free_count, e.fc); end
      if (alloc_reg !== e.regs) begin errors++; $display("FAIL fill_%0d regs got %h exp %h", c, alloc_reg, e.regs); end
      if (double_free_err !== e.err) begin errors++; $display("FAIL fill_%0d err got %b exp %b", c, double_free_err, e.err); end
      if (c == 10) begin
        checks++;
        if (alloc_reg !== {6'd35, 6'd34, 6'd33, 6'd32}) begin errors++; $display("FAIL fill_reissue lanes got %h exp 32..35", alloc_reg); end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 3)
        drive_cycle(4'b1111, '0, '0, '0, 1'b0, "pre_flush");
      else if (c == 3)
        drive_cycle(4'b1111, 4'b1111, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b1, "flush");
      else
        drive_cycle(4'b1111, '0, '0, '0, 1'b0, "post_flush");
      e = sb_q.pop_front();
      checks += 4;
      if (alloc_ready !== e.rdy) begin errors++; $display("FAIL flush_%0d ready got %b exp %b", c, alloc_ready, e.rdy); end
      if (free_count !== e.fc) begin errors++; $display("FAIL flush_%0d fc got %0d exp %0d", c, free_count, e.fc); end
      if (alloc_reg !== e.regs) begin errors++; $display("FAIL flush_%0d regs got %h exp %h", c, alloc_reg, e.regs); end
      if (double_free_err !== e.err) begin errors++; $display("FAIL flush_%0d err got %b exp %b", c, double_free_err, e.err); end
      if (c == 4) begin
        checks++;
        if (alloc_reg !== {6'd39, 6'd38, 6'd37, 6'd36}) begin errors++; $display("FAIL post_flush lanes got %h exp 36..39", alloc_reg); end
      end
      advance();
      if (c == 3) begin
        checks++;
        if (free_count !== 7'd32) begin errors++; $display("FAIL flush fc_after got %0d exp 32", free_count); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [AW-1:0] av;
    logic [FW-1:0] cv, ca;
    logic [FW*PW-1:0] cfr;
    logic fl;
    int avail, old;
    do_reset();
    for (int c = 0; c < 200; c++) begin
      av = AW'($urandom);
      cv = FW'($urandom);
      ca = '0;
      cfr = '0;
      fl = ($urandom_range(0, 15) == 0);
      avail = n_spec;
      for (int j = 0; j < FW; j++) begin
        if (cv[j] && avail > 0 && $urandom_range(0, 3) != 0) begin
          ca[j] = 1'b1;
          avail--;
          old = (pool.size() == 0 || $urandom_range(0, 15) == 0) ? 0 : pool.pop_front();
          cfr[j*PW +: PW] = PW'(old);
        end
      end
      for (int q = 0; q < n_spec - avail; q++) pool.push_back(lst[q]);
      drive_cycle(av, cv, ca, cfr, fl, "b2b");
      e = sb_q.pop_front();
      checks += 4;
      if (alloc_ready !== e.rdy) begin errors++; $display("FAIL b2b_%0d ready got %b exp %b", c, alloc_ready, e.rdy); end
      if (free_count !== e.fc) begin errors++; $display("FAIL b2b_%0d fc got %0d exp %0d", c, free_count, e.fc); end
      if (alloc_reg !== e.regs) begin errors++; $display("FAIL b2b_%0d regs got %h exp %h", c, alloc_reg, e.regs); end
      if (double_free_err !== e.err) begin errors++; $display("FAIL b2b_%0d err got %b exp %b", c, double_free_err, e.err); end
      advance();
    end
  endtask

  task automatic test_double_free();
    exp_t e;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c == 0)
        drive_cycle(4'b0001, '0, '0, '0, 1'b0, "df_alloc");
      else if (c == 1)
        drive_cycle('0, 4'b0001, 4'b0001, {18'd0, 6'd40}, 1'b0, "df_free40");
      else
        drive_cycle('0, '0, '0, '0, 1'b0, "df_idle");
      e = sb_q.pop_front();
      checks += 3;
      if (alloc_ready !== e.rdy) begin errors++; $display("FAIL df_%0d ready got %b exp %b", c, alloc_ready, e.rdy); end
      if (free_count !== e.fc) begin errors++; $display("FAIL df_%0d fc got %0d exp %0d", c, free_count, e.fc); end
      if (double_free_err !== e.err) begin errors++; $display("FAIL df_%0d err got %b exp %b", c, double_free_err, e.err); end
      if (c >= 2) begin
        checks++;
        if (double_free_err !== DFC_EN) begin errors++; $display("FAIL df_sticky_%0d err got %b exp %b", c, double_free_err, DFC_EN); end
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc_all();
    test_sparse();
    test_fill_wrap();
    test_flush();
    test_back_to_back();
    test_double_free();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "simulation time limit reached");
  end
endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Physical-register free list for the rename stage: a circular queue of free physical register indices.
- Rename lanes pop from the head. Committed instructions push the stale mapping back at the tail.
- A separate committed-head pointer advances on commit, so a pipeline flush can reclaim every speculative allocation in one cycle.
- Sits between the rename stage (allocation side) and ROB commit (return side).

Parameters:
- PHYS_REGS, 64, physical register count and queue depth; must be a power of 2.
- ARCH_REGS, 32, architectural register count; phys 0..ARCH_REGS-1 are mapped at reset.
- ALLOC_WIDTH, 4, rename lanes allocating per cycle.
- FREE_WIDTH, 4, commit lanes freeing per cycle.
- PW, $clog2(PHYS_REGS), physical index width (derived).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  async active-high reset.
- alloc_valid  in  ALLOC_WIDTH  per-lane allocation request.
- alloc_ready  out  1  list can satisfy a full ALLOC_WIDTH request this cycle.
- alloc_reg  out  ALLOC_WIDTH*PW  granted physical index per lane.
- commit_valid  in  FREE_WIDTH  per-lane instruction commit.
- commit_alloc  in  FREE_WIDTH  committed instruction had allocated a register at rename.
- commit_free_reg  in  FREE_WIDTH*PW  stale physical register to return.
- flush  in  1  mispredict/exception recovery.
- free_count  out  PW+1  current number of free entries.
- double_free_err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Storage:
  - PHYS_REGS x PW entry array.
  - Pointers head, tail, commit_head, each PW+1 bits (MSB = wrap bit).
  - free_count = tail - head, taken modulo 2^(PW+1).
- Reset (async):
  - Entry i holds ARCH_REGS+i for i < PHYS_REGS-ARCH_REGS; remaining entries are 0.
  - head = commit_head = 0; tail = PHYS_REGS-ARCH_REGS (free_count 32 with defaults).
  - alloc_ready = 1; double_free_err = 0.
- alloc_ready = (free_count >= ALLOC_WIDTH) && !flush. Combinational from registered pointers. Same-cycle frees are not counted.
- Allocation:
  - Lane i fires when alloc_valid[i] && alloc_ready.
  - Requests are compacted: lane i reads entry head + popcount(alloc_valid[i-1:0]).
  - alloc_reg is combinational, same-cycle, zero latency.
  - head += popcount(fired lanes) at the clock edge.
  - Lanes without a request drive alloc_reg = 0.
  - When alloc_ready = 0, no lane fires and head holds. Rename stalls upstream.
- Free:
  - Lane j frees when commit_valid[j] && commit_alloc[j] && commit_free_reg[j] != 0. Phys 0 (x0) is never returned.
  - Freed registers are written to tail + popcount of earlier freeing lanes; tail advances by that count.
  - Freed entries are allocatable starting the next cycle, never the same cycle.
- Commit pointer: commit_head += popcount(commit_valid & commit_alloc). This counts lanes whose old reg is 0, because the new register was still consumed from the list.
- Flush:
  - Allocation is suppressed this cycle.
  - head <= next commit_head, i.e. including this cycle's commit advance.
  - Frees and commit-head advance still apply in the flush cycle.
  - Next cycle: free_count = tail_next - commit_head_next.
- Simultaneous alloc and free: head and tail update independently; free_count_next = free_count - allocs + frees.
- Wrap-around: pointers increment modulo 2^(PW+1); the array index uses the low PW bits.
- Overflow (free_count would exceed PHYS_REGS) cannot occur with a legal ROB. No check in base build.
- Underflow is prevented by alloc_ready gating.

Optional Feature:
- Macro: FREE_LIST_DOUBLE_FREE_CHECK_EN.
- Defined:
  - Keep a PHYS_REGS-bit in_list vector. Reset value: bits ARCH_REGS..PHYS_REGS-1 set.
  - Clear bit on allocation; set bit on free.
  - On flush, recompute in_list from the array between commit_head and tail.
  - Freeing a register whose bit is already set, or freeing the same reg on two lanes in one cycle, sets double_free_err sticky until reset. The free still proceeds.
- Undefined: no vector is built; double_free_err is tied 0.

Test Plan:
- Reset, no activity -> free_count=32, alloc_ready=1, alloc_reg all 0.
- alloc_valid=4'b1111 one cycle -> alloc_reg lanes = 32,33,34,35; next cycle free_count=28.
- alloc_valid=4'b1010 -> lane1=32, lane3=33, lanes 0/2 = 0; free_count=30.
- Allocate 4/cycle for 8 cycles -> free_count=0, alloc_ready=0, head unchanged on further requests. Then commit 4 lanes freeing 32..35 -> alloc_ready=1 next cycle, those regs reissued after wrap.
- Allocate 12 regs, commit 4 (commit_alloc=1, old regs 1..4), flush in the same cycle -> next cycle head=commit_head=4, free_count=32; next allocations return 36,37,38,39.
- With FREE_LIST_DOUBLE_FREE_CHECK_EN: free reg 40 while still in list -> double_free_err=1 next cycle and it stays 1. Without the macro -> double_free_err stays 0.
